// File: rtl/i2c_slave_fsm.sv
// i2c_slave_fsm -- I2C target controller for the on-chip I2C master's bus.
//   Detects START/STOP, matches a 7-bit own address, receives bytes into an
//   RX FIFO interface and transmits bytes popped from a TX FIFO interface.
//   The bus is driven open-drain only, through low-enable outputs.
// Ports:
//   i2c_core_clk_i, reset_i (sync, active high)
//   own_addr_i           target address
//   scl_i, sda_i         pin feedback
//   sda_low_en_o         1 = pull SDA low
//   scl_low_en_o         1 = pull SCL low (clock stretch)
//   rx_data_o/rx_valid_o received byte and one-cycle valid pulse
//   rx_full_i            RX FIFO full
//   tx_data_i/tx_empty_i TX FIFO head and empty flag; tx_rinc_o pops it
//   busy_o, addr_match_o bus-busy and addressed status
// Build option: define I2C_SLAVE_CLK_STRETCH_EN to stretch SCL instead of
//   sending 0xFF on TX underflow or NACKing on RX overflow.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | bus free, waiting for START
// ADDR      | shifting in the address/rw byte
// ADDR_ACK  | sub 0: drive ACK on next fall; sub 1: release on next fall
// RX_DATA   | shifting in a data byte from the master
// RX_ACK    | sub 0: ACK/NACK on fall; sub 1: release; sub 2/3: stretch
// TX_DATA   | sub 0: shifting out a byte; sub 2/3: stretch on underflow
// TX_ACK    | sub 0: sample master ACK; sub 1: load next byte on fall
// WAIT_STOP | not addressed or NACKed; wait for STOP or repeated START
module i2c_slave_fsm #(
  parameter int DATA_SIZE   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i2c_core_clk_i,
  input  logic                 reset_i,
  input  logic [6:0]           own_addr_i,
  input  logic                 scl_i,
  input  logic                 sda_i,
  output logic                 sda_low_en_o,
  output logic                 scl_low_en_o,
  output logic [DATA_SIZE-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_full_i,
  input  logic [DATA_SIZE-1:0] tx_data_i,
  input  logic                 tx_empty_i,
  output logic                 tx_rinc_o,
  output logic                 busy_o,
  output logic                 addr_match_o
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic                   scl_hist_q, sda_hist_q;
  logic                   scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  state_t                 state_q, state_d;
  logic [1:0]             sub_q, sub_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_SIZE-1:0]   shift_q, shift_d, shift_in;
  logic [DATA_SIZE-1:0]   rx_data_q, rx_data_d;
  logic                   rw_q, rw_d;
  logic                   sda_low_en_q, sda_low_en_d;
  logic                   rx_valid_q, rx_valid_d, rx_pend_q, rx_pend_d;
  logic                   tx_rinc_q, tx_rinc_d;
  logic                   busy_q, busy_d, addr_match_q, addr_match_d;
  logic                   accept_q, accept_d;
  logic                   tx_enter;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
  logic                   scl_low_en_q, scl_low_en_d;
`endif

  // Synchronizers shift toward the MSB; the history flop holds the previous
  // synchronized value so edges are seen SYNC_STAGES+1 cycles after the pin.
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s & scl_hist_q;
  assign start_det = scl_s & scl_hist_q & ~sda_s & sda_hist_q;
  assign stop_det  = scl_s & scl_hist_q & sda_s & ~sda_hist_q;
  assign shift_in  = {shift_q[DATA_SIZE-2:0], sda_s};

  always_comb begin
    state_d      = state_q;
    sub_d        = sub_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    rw_d         = rw_q;
    sda_low_en_d = sda_low_en_q;
    rx_data_d    = rx_data_q;
    rx_pend_d    = 1'b0;
    rx_valid_d   = rx_pend_q;
    tx_rinc_d    = 1'b0;
    busy_d       = busy_q;
    addr_match_d = addr_match_q;
    accept_d     = accept_q;
    tx_enter     = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    scl_low_en_d = scl_low_en_q;
`endif

    case (state_q)
      ADDR: if (scl_rise) begin
        shift_d   = shift_in;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          rw_d    = sda_s;
          sub_d   = 2'd0;
          state_d = (shift_in[DATA_SIZE-1:1] == own_addr_i) ? ADDR_ACK : WAIT_STOP;
        end
      end
      ADDR_ACK: if (scl_fall) begin
        if (sub_q == 2'd0) begin
          sda_low_en_d = 1'b1;
          addr_match_d = 1'b1;
          sub_d        = 2'd1;
        end else begin
          sda_low_en_d = 1'b0;
          bit_cnt_d    = 3'd0;
          sub_d        = 2'd0;
          if (rw_q) tx_enter = 1'b1;
          else      state_d  = RX_DATA;
        end
      end
      RX_DATA: if (scl_rise) begin
        shift_d   = shift_in;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          rx_data_d = shift_in;
          accept_d  = ~rx_full_i;
          rx_pend_d = ~rx_full_i;
          sub_d     = 2'd0;
          state_d   = RX_ACK;
        end
      end
      RX_ACK: begin
        case (sub_q)
          2'd0: if (scl_fall) begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
            if (!accept_q && rx_full_i) begin
              scl_low_en_d = 1'b1;
              sub_d        = 2'd2;
            end else begin
              rx_pend_d    = ~accept_q;
              accept_d     = 1'b1;
              sda_low_en_d = 1'b1;
              sub_d        = 2'd1;
            end
`else
            sda_low_en_d = accept_q;
            sub_d        = 2'd1;
`endif
          end
          2'd1: if (scl_fall) begin
            sda_low_en_d = 1'b0;
            bit_cnt_d    = 3'd0;
            sub_d        = 2'd0;
            state_d      = accept_q ? RX_DATA : WAIT_STOP;
          end
`ifdef I2C_SLAVE_CLK_STRETCH_EN
          // ACK goes out one cycle before SCL is released for SDA setup.
          2'd2: if (!rx_full_i) begin
            rx_pend_d    = 1'b1;
            accept_d     = 1'b1;
            sda_low_en_d = 1'b1;
            sub_d        = 2'd3;
          end
          2'd3: begin
            scl_low_en_d = 1'b0;
            sub_d        = 2'd1;
          end
`endif
          default: ;
        endcase
      end
      TX_DATA: begin
        case (sub_q)
          2'd0: begin
            if (scl_rise) begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end else if (scl_fall) begin
              // Counter wraps to 0 after the 8th rising edge: byte done.
              if (bit_cnt_q == 3'd0) begin
                sda_low_en_d = 1'b0;
                state_d      = TX_ACK;
              end else begin
                shift_d      = {shift_q[DATA_SIZE-2:0], 1'b1};
                sda_low_en_d = ~shift_q[DATA_SIZE-2];
              end
            end
          end
`ifdef I2C_SLAVE_CLK_STRETCH_EN
          2'd2: if (!tx_empty_i) begin
            shift_d      = tx_data_i;
            tx_rinc_d    = 1'b1;
            sda_low_en_d = ~tx_data_i[DATA_SIZE-1];
            sub_d        = 2'd3;
          end
          2'd3: begin
            scl_low_en_d = 1'b0;
            sub_d        = 2'd0;
          end
`endif
          default: ;
        endcase
      end
      TX_ACK: begin
        if (sub_q == 2'd0) begin
          if (scl_rise) begin
            if (sda_s) state_d = WAIT_STOP;
            else       sub_d   = 2'd1;
          end
        end else if (scl_fall) begin
          tx_enter = 1'b1;
        end
      end
      default: ;
    endcase

    if (tx_enter) begin
      state_d   = TX_DATA;
      bit_cnt_d = 3'd0;
      sub_d     = 2'd0;
      if (!tx_empty_i) begin
        shift_d      = tx_data_i;
        tx_rinc_d    = 1'b1;
        sda_low_en_d = ~tx_data_i[DATA_SIZE-1];
      end else begin
        sda_low_en_d = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        scl_low_en_d = 1'b1;
        sub_d        = 2'd2;
`else
        shift_d      = '1;
`endif
      end
    end

    // STOP has priority over START when both are flagged together.
    if (stop_det) begin
      state_d      = IDLE;
      sub_d        = 2'd0;
      sda_low_en_d = 1'b0;
      busy_d       = 1'b0;
      addr_match_d = 1'b0;
      rx_pend_d    = 1'b0;
      tx_rinc_d    = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      scl_low_en_d = 1'b0;
`endif
    end else if (start_det) begin
      state_d      = ADDR;
      sub_d        = 2'd0;
      bit_cnt_d    = 3'd0;
      sda_low_en_d = 1'b0;
      busy_d       = 1'b1;
      addr_match_d = 1'b0;
      rx_pend_d    = 1'b0;
      tx_rinc_d    = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      scl_low_en_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge i2c_core_clk_i) begin
    if (reset_i) begin
      scl_sync_q   <= '1;
      sda_sync_q   <= '1;
      scl_hist_q   <= 1'b1;
      sda_hist_q   <= 1'b1;
      state_q      <= IDLE;
      sub_q        <= 2'd0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= '0;
      rw_q         <= 1'b0;
      sda_low_en_q <= 1'b0;
      rx_data_q    <= '0;
      rx_pend_q    <= 1'b0;
      rx_valid_q   <= 1'b0;
      tx_rinc_q    <= 1'b0;
      busy_q       <= 1'b0;
      addr_match_q <= 1'b0;
      accept_q     <= 1'b0;
    end else begin
      scl_sync_q   <= scl_sync_d;
      sda_sync_q   <= sda_sync_d;
      scl_hist_q   <= scl_s;
      sda_hist_q   <= sda_s;
      state_q      <= state_d;
      sub_q        <= sub_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rw_q         <= rw_d;
      sda_low_en_q <= sda_low_en_d;
      rx_data_q    <= rx_data_d;
      rx_pend_q    <= rx_pend_d;
      rx_valid_q   <= rx_valid_d;
      tx_rinc_q    <= tx_rinc_d;
      busy_q       <= busy_d;
      addr_match_q <= addr_match_d;
      accept_q     <= accept_d;
    end
  end

`ifdef I2C_SLAVE_CLK_STRETCH_EN
  always_ff @(posedge i2c_core_clk_i) begin
    if (reset_i) scl_low_en_q <= 1'b0;
    else         scl_low_en_q <= scl_low_en_d;
  end
  assign scl_low_en_o = scl_low_en_q;
`else
  assign scl_low_en_o = 1'b0;
`endif

  assign sda_low_en_o = sda_low_en_q;
  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign tx_rinc_o    = tx_rinc_q;
  assign busy_o       = busy_q;
  assign addr_match_o = addr_match_q;

endmodule

// File: tb/tb_i2c_slave_fsm.sv
// Testbench for i2c_slave_fsm: a bus-level I2C master model drives SCL/SDA
// (wired-AND with the DUT's low-enables), FIFO models sit on the RX/TX sides.
module tb_i2c_slave_fsm;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_i;
  logic [6:0] own_addr;
  logic       scl_m, sda_m, scl_bus, sda_bus;
  logic       sda_low_en, scl_low_en;
  logic [7:0] rx_data;
  logic       rx_valid, rx_full;
  logic [7:0] tx_data;
  logic       tx_empty, tx_rinc, busy, addr_match;

  assign scl_bus = scl_m & ~scl_low_en;
  assign sda_bus = sda_m & ~sda_low_en;

  i2c_slave_fsm #(.DATA_SIZE(8), .SYNC_STAGES(2)) dut (
    .i2c_core_clk_i (clk),
    .reset_i        (reset_i),
    .own_addr_i     (own_addr),
    .scl_i          (scl_bus),
    .sda_i          (sda_bus),
    .sda_low_en_o   (sda_low_en),
    .scl_low_en_o   (scl_low_en),
    .rx_data_o      (rx_data),
    .rx_valid_o     (rx_valid),
    .rx_full_i      (rx_full),
    .tx_data_i      (tx_data),
    .tx_empty_i     (tx_empty),
    .tx_rinc_o      (tx_rinc),
    .busy_o         (busy),
    .addr_match_o   (addr_match)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Event counters sampled on the falling core-clock edge.
  int rx_valid_cnt = 0, tx_pops = 0, sda_low_cnt = 0, scl_low_cnt = 0;
  always @(negedge clk) begin
    if (rx_valid)   rx_valid_cnt++;
    if (tx_rinc)    tx_pops++;
    if (sda_low_en) sda_low_cnt++;
    if (scl_low_en) scl_low_cnt++;
  end

  // TX FIFO model: head index follows the DUT's pops.
  logic [7:0] tx_q [4];
  int         tx_n = 0, tx_base = 0, head;
  always_comb begin
    head     = tx_pops - tx_base;
    tx_empty = !(head < tx_n);
    tx_data  = 8'h00;
    if (head >= 0 && head < tx_n) tx_data = tx_q[head[1:0]];
  end

  task automatic fifo_set(input int n, input logic [7:0] b0, input logic [7:0] b1);
    tx_q[0] = b0;
    tx_q[1] = b1;
    tx_base = tx_pops;
    tx_n    = n;
  endtask

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: actual %0h required %0h", nm, idx, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_up();
    int i;
    scl_m = 1'b1;
    for (i = 0; i < 500 && !scl_bus; i++) @(negedge clk);
    if (!scl_bus) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scl_release_timeout: actual 0 required 1");
    end
  endtask

  task automatic m_start();
    sda_m = 1'b1; scl_m = 1'b1; wait_clk(8);
    sda_m = 1'b0; wait_clk(8);
    scl_m = 1'b0; wait_clk(4);
  endtask

  task automatic m_rstart();
    sda_m = 1'b1; wait_clk(4);
    scl_up(); wait_clk(8);
    sda_m = 1'b0; wait_clk(8);
    scl_m = 1'b0; wait_clk(4);
  endtask

  task automatic m_stop();
    sda_m = 1'b0; wait_clk(4);
    scl_up(); wait_clk(8);
    sda_m = 1'b1; wait_clk(8);
  endtask

  task automatic m_bit(input logic b, output logic r);
    sda_m = b; wait_clk(4);
    scl_up(); wait_clk(4);
    r = sda_bus; wait_clk(4);
    scl_m = 1'b0; wait_clk(4);
  endtask

  task automatic m_write(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) m_bit(b[i], r);
    m_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic m_read(input logic ack, output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, r);
      b[i] = r;
    end
    m_bit(~ack, r);
  endtask

  task automatic check_idle_outputs(input string nm);
    check({nm, "_sda"},   0, sda_low_en, 0);
    check({nm, "_scl"},   0, scl_low_en, 0);
    check({nm, "_rxd"},   0, rx_data,    0);
    check({nm, "_rxv"},   0, rx_valid,   0);
    check({nm, "_rinc"},  0, tx_rinc,    0);
    check({nm, "_busy"},  0, busy,       0);
    check({nm, "_match"}, 0, addr_match, 0);
  endtask

  typedef struct {
    logic [6:0] own;
    logic [7:0] addr_b;
    logic [7:0] data_b;
    logic       full;
    logic       exp_aack;
    logic       exp_dack;
    int         exp_nvalid;
    logic [7:0] exp_rx;
  } wvec_t;

  wvec_t vec [6];
  int    nv;

  initial begin
    logic       ack;
    logic [7:0] b;
    int         v0, p0;

    vec[0] = '{7'h50, 8'hA0, 8'hA5, 1'b0, 1'b1, 1'b1, 1, 8'hA5};
    vec[1] = '{7'h50, 8'hA2, 8'h5A, 1'b0, 1'b0, 1'b0, 0, 8'hA5};
    vec[2] = '{7'h7F, 8'hFE, 8'h00, 1'b0, 1'b1, 1'b1, 1, 8'h00};
    vec[3] = '{7'h00, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1, 1, 8'hFF};
    vec[4] = '{7'h2A, 8'h54, 8'h81, 1'b0, 1'b1, 1'b1, 1, 8'h81};
    vec[5] = '{7'h50, 8'hA0, 8'h3C, 1'b1, 1'b1, 1'b0, 0, 8'h3C};
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    nv = 5;
`else
    nv = 6;
`endif

    reset_i  = 1'b1;
    scl_m    = 1'b1;
    sda_m    = 1'b1;
    rx_full  = 1'b0;
    own_addr = 7'h50;
    wait_clk(3);
    check_idle_outputs("reset");
    reset_i = 1'b0;
    wait_clk(4);

    // Write transactions: address byte then one data byte, then STOP.
    for (int v = 0; v < nv; v++) begin
      own_addr = vec[v].own;
      rx_full  = vec[v].full;
      v0       = rx_valid_cnt;
      p0       = sda_low_cnt;
      m_start();
      check("busy_start", v, busy, 1);
      m_write(vec[v].addr_b, ack);
      check("addr_ack", v, ack, vec[v].exp_aack);
      check("addr_match", v, addr_match, vec[v].exp_aack);
      m_write(vec[v].data_b, ack);
      check("data_ack", v, ack, vec[v].exp_dack);
      rx_full = 1'b0;
      m_stop();
      check("busy_stop", v, busy, 0);
      check("match_stop", v, addr_match, 0);
      check("rx_valid_cnt", v, rx_valid_cnt - v0, vec[v].exp_nvalid);
      check("rx_data", v, rx_data, vec[v].exp_rx);
      check("sda_driven", v, (sda_low_cnt != p0), vec[v].exp_aack);
    end

    own_addr = 7'h50;

    // Read: two bytes, master ACKs the first and NACKs the second.
    fifo_set(2, 8'h3C, 8'hC3);
    p0 = tx_pops;
    m_start();
    m_write(8'hA1, ack);
    check("rd_addr_ack", 0, ack, 1);
    m_read(1'b1, b);
    check("rd_byte0", 0, b, 8'h3C);
    m_read(1'b0, b);
    check("rd_byte1", 0, b, 8'hC3);
    wait_clk(4);
    check("rd_pops", 0, tx_pops - p0, 2);
    check("rd_sda_released", 0, sda_low_en, 0);
    check("rd_busy", 0, busy, 1);
    check("rd_match", 0, addr_match, 1);
    m_stop();
    check("rd_busy_stop", 0, busy, 0);

`ifndef I2C_SLAVE_CLK_STRETCH_EN
    // RX FIFO full on the second byte: NACK, no valid, then ignored bytes.
    v0 = rx_valid_cnt;
    m_start();
    m_write(8'hA0, ack);
    check("full_addr_ack", 0, ack, 1);
    m_write(8'h11, ack);
    check("full_b0_ack", 0, ack, 1);
    rx_full = 1'b1;
    m_write(8'h22, ack);
    check("full_b1_ack", 0, ack, 0);
    rx_full = 1'b0;
    m_write(8'h33, ack);
    check("full_b2_ack", 0, ack, 0);
    check("full_valid_cnt", 0, rx_valid_cnt - v0, 1);
    check("full_rx_data", 0, rx_data, 8'h22);
    m_stop();

    // Empty TX FIFO: 0xFF goes out with no pop.
    fifo_set(0, 8'h00, 8'h00);
    p0 = tx_pops;
    m_start();
    m_write(8'hA1, ack);
    m_read(1'b0, b);
    check("empty_byte", 0, b, 8'hFF);
    check("empty_pops", 0, tx_pops - p0, 0);
    m_stop();
`endif

    // Repeated START after 4 data bits, then a read.
    fifo_set(1, 8'h96, 8'h00);
    v0 = rx_valid_cnt;
    p0 = tx_pops;
    m_start();
    m_write(8'hA0, ack);
    m_bit(1'b1, ack);
    m_bit(1'b0, ack);
    m_bit(1'b1, ack);
    m_bit(1'b0, ack);
    m_rstart();
    check("rs_match_cleared", 0, addr_match, 0);
    m_write(8'hA1, ack);
    check("rs_addr_ack", 0, ack, 1);
    m_read(1'b0, b);
    check("rs_byte", 0, b, 8'h96);
    check("rs_valid_cnt", 0, rx_valid_cnt - v0, 0);
    check("rs_pops", 0, tx_pops - p0, 1);
    m_stop();

    // reset_i mid TX byte while the DUT is pulling SDA low.
    fifo_set(1, 8'h00, 8'h00);
    m_start();
    m_write(8'hA1, ack);
    m_bit(1'b1, ack);
    m_bit(1'b1, ack);
    m_bit(1'b1, ack);
    check("pre_reset_sda", 0, sda_low_en, 1);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    check_idle_outputs("mid_reset");
    m_stop();
    check("post_reset_sda", 0, sda_low_en, 0);

`ifdef I2C_SLAVE_CLK_STRETCH_EN
    // Underflow stretch: FIFO empty for 20 cycles once SCL is held, then
    // one more held cycle while the first bit sets up on SDA.
    fifo_set(0, 8'h00, 8'h00);
    p0 = tx_pops;
    m_start();
    v0 = scl_low_cnt;
    m_write(8'hA1, ack);
    check("st_addr_ack", 0, ack, 1);
    fork
      m_read(1'b0, b);
      begin
        int i;
        for (i = 0; i < 2000 && (scl_low_cnt - v0) < 20; i++) begin
          @(negedge clk);
          #1;
        end
        if ((scl_low_cnt - v0) < 20) begin
          n_cmp++;
          n_bad++;
          $display("FAIL st_wait_timeout: actual %0d required 20", scl_low_cnt - v0);
        end
        fifo_set(1, 8'h5A, 8'h00);
      end
    join
    check("st_byte", 0, b, 8'h5A);
    check("st_scl_cycles", 0, scl_low_cnt - v0, 21);
    check("st_pops", 0, tx_pops - p0, 1);
    m_stop();
    check("st_scl_released", 0, scl_low_en, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

endmodule

// File: doc/i2c_slave_fsm.md
Name: i2c_slave_fsm

Overview:
- I2C target (slave) controller: the responder for the team's I2C master on the same SDA/SCL bus.
- Detects START/STOP, matches a 7-bit own address and ACKs it.
- Write transactions: received bytes go out on a byte-valid interface toward an RX FIFO.
- Read transactions: bytes are pulled from a TX FIFO and shifted onto SDA. Drives the bus open-drain only, via low-enable outputs.

Parameters:
- DATA_SIZE, 8, byte width; fixed at 8 for I2C, parameterised only for datapath consistency.
- SYNC_STAGES, 2, synchronizer flops on scl_i/sda_i (minimum 2).

Ports:
- i2c_core_clk_i  in  1  core clock; must be >= 8x SCL frequency.
- reset_i  in  1  synchronous, active-high reset.
- own_addr_i  in  7  target address; sampled at the address-compare point.
- scl_i  in  1  SCL line feedback (pin value).
- sda_i  in  1  SDA line feedback (pin value).
- sda_low_en_o  out  1  1 = pull SDA low; 0 = release (high-Z).
- scl_low_en_o  out  1  1 = pull SCL low (clock stretch); constant 0 without the optional feature.
- rx_data_o  out  DATA_SIZE  last received byte.
- rx_valid_o  out  1  one-cycle pulse: rx_data_o is new.
- rx_full_i  in  1  RX FIFO full.
- tx_data_i  in  DATA_SIZE  head of TX FIFO.
- tx_empty_i  in  1  TX FIFO empty.
- tx_rinc_o  out  1  one-cycle pulse: pop TX FIFO.
- busy_o  out  1  1 from START to STOP.
- addr_match_o  out  1  1 from address ACK until STOP or repeated START.

Behaviour:
- Reset values (reset_i=1 at clock edge): all outputs 0; rx_data_o=0; state IDLE; bit counter 0; synchronizer flops preset to 1 (idle bus).
- Inputs are synchronized through SYNC_STAGES flops plus one history flop.
- Edge flags are derived from the synchronized signals. Pin-to-decision latency is SYNC_STAGES+1 cycles.
- START is SDA falling while SCL high. In any state it forces state ADDR, clears the bit counter, releases SDA and sets busy_o.
- STOP is SDA rising while SCL high. In any state it forces IDLE, releases SDA/SCL and clears busy_o/addr_match_o.
- If START and STOP are both detected in the same cycle, STOP wins.
- SDA is sampled on the SCL rising-edge flag. sda_low_en_o changes only on the SCL falling-edge flag. Data is MSB first.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. On the 8th rising edge, compare byte[7:1] with own_addr_i and latch rw=byte[0]. Match -> ADDR_ACK. Mismatch -> WAIT_STOP (SDA never driven).
  - ADDR_ACK: on the next falling edge assert sda_low_en_o. On the falling edge after the ACK clock, release SDA; rw=0 -> RX_DATA; rw=1 -> TX_DATA.
  - TX_DATA entry (same falling edge as leaving ADDR_ACK or TX_ACK):
    - tx_empty_i=0: load tx_data_i into the shift register, pulse tx_rinc_o and drive bit 7.
    - tx_empty_i=1: transmit 0xFF with no pop.
  - RX_DATA: shift 8 bits. On the 8th rising edge, rx_data_o <= byte. If rx_full_i=0, pulse rx_valid_o one cycle later; then -> RX_ACK.
  - RX_ACK: on the falling edge drive ACK (low) if the byte was accepted; otherwise release (NACK). On the next falling edge release; accepted -> RX_DATA, NACK -> WAIT_STOP.
  - TX_DATA: sda_low_en_o = ~shift[7] on each falling edge. After the 8th bit's falling edge, release SDA -> TX_ACK.
  - TX_ACK: sample the master's bit on the rising edge. 0 (ACK) -> TX_DATA, loading the next byte on the following falling edge. 1 (NACK) -> WAIT_STOP.
  - WAIT_STOP: SDA released; wait for STOP or repeated START.
- Bit counter is 3 bits and wraps 7->0 per byte. A repeated START mid-byte discards the partial byte with no rx_valid_o.
- reset_i mid-transfer returns to IDLE on that clock edge and releases the bus immediately.

Optional Feature:
- Macro: I2C_SLAVE_CLK_STRETCH_EN.
- Defined: stretch the clock instead of sending 0xFF or NACKing.
  - TX_DATA entry with tx_empty_i=1: assert scl_low_en_o on that falling edge and hold it until tx_empty_i=0, then load, pop, drive bit 7 and release SCL one cycle later.
  - RX_ACK with rx_full_i=1: hold SCL low until rx_full_i=0, then pulse rx_valid_o and ACK.
- Undefined: scl_low_en_o tied 0; behaviour as specified above.

Test Plan:
- own_addr 0x50; master writes addr byte 0xA0, data 0xA5, STOP -> ACK on address and data; rx_data_o=0xA5 with exactly one rx_valid_o pulse; busy_o drops after STOP.
- Master addresses 0x51 (byte 0xA2) -> sda_low_en_o stays 0 throughout; addr_match_o=0; IDLE after STOP.
- Read: master sends byte 0xA1; tx_data 0x3C then 0xC3; master ACKs, then NACKs -> SDA shows 0x3C, 0xC3; two tx_rinc_o pulses; WAIT_STOP after NACK.
- Write with rx_full_i=1 on the second byte -> first byte ACKed; second byte NACKed with no rx_valid_o; WAIT_STOP.
- Repeated START after 4 data bits, then read address 0xA1 -> partial byte dropped; address ACKed; TX begins.
- reset_i pulse mid-TX byte -> all outputs 0 next cycle.
- With I2C_SLAVE_CLK_STRETCH_EN and tx_empty_i=1 for 20 cycles -> scl_low_en_o high for those cycles; byte sent correctly after.
